window_fetch: RTL

//   Datapath responder to the Sobel controller's read commands. On start_9_read it

---
 rtl/window_fetch_if.sv | 14 +
 rtl/window_fetch.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/window_fetch_if.sv
// Image-memory read bus between the window fetcher (master) and the pixel memory (slave).
// One outstanding request; read_valid may arrive in the first read_en cycle.
interface window_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int PIX_W  = 8
);
  logic              read_en;
  logic [ADDR_W-1:0] read_addr;
  logic [PIX_W-1:0]  read_data;
  logic              read_valid;

  modport master (output read_en, output read_addr, input read_data, input read_valid);
  modport slave  (input read_en, input read_addr, output read_data, output read_valid);
endinterface

// File: rtl/window_fetch.sv
// Fetches a 3x3 pixel window (full fetch) or slides it one column right and fetches
// only the new right column (shift), one pixel per memory handshake.
module window_fetch #(
  parameter int ADDR_W = 16,
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 640
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start_9_read,
  input  logic               start_shift,
  input  logic [ADDR_W-1:0]  base_addr,
  window_fetch_if.master     mem,
  output logic [9*PIX_W-1:0] window,
  output logic               read_data_done,
  output logic               shift_done,
  output logic               busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] W_PITCH = ADDR_W'(IMG_W);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [1:0]        r_row;
  logic [1:0]        r_col;
  logic              r_read_en;
  logic [ADDR_W-1:0] r_read_addr;
  logic              r_read_data_done;
  logic              r_shift_done;
  logic              r_busy;
  logic [PIX_W-1:0]  r_pix [9];

  logic [1:0] w_next_row;
  logic [1:0] w_next_col;
  logic       w_last;
  logic [3:0] w_cap_idx;

  function automatic logic [ADDR_W-1:0] f_addr(input logic [ADDR_W-1:0] base,
                                              input logic [1:0] row,
                                              input logic [1:0] col);
    return base + ADDR_W'(row) * W_PITCH + ADDR_W'(col);
  endfunction

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_row = r_row;
    w_next_col = r_col + 2'd1;
    if (r_state == S_SHIFT) begin
      w_next_row = r_row + 2'd1;
      w_next_col = 2'd2;
    end else if (r_col == 2'd2) begin
      w_next_row = r_row + 2'd1;
      w_next_col = 2'd0;
    end
  end

  assign w_last    = (r_state == S_SHIFT) ? (r_row == 2'd2) : (r_row == 2'd2 && r_col == 2'd2);
  assign w_cap_idx = 4'(r_row) * 4'd3 + 4'(r_col);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state          <= S_IDLE;
      r_base           <= '0;
      r_row            <= '0;
      r_col            <= '0;
      r_read_en        <= 1'b0;
      r_read_addr      <= '0;
      r_read_data_done <= 1'b0;
      r_shift_done     <= 1'b0;
      r_busy           <= 1'b0;
      // NOTE: the pixel array is reset on purpose: an aborted fetch must leave a zeroed window.
      for (int i = 0; i < 9; i++) r_pix[i] <= '0;
    end else begin
      r_read_data_done <= 1'b0;
      r_shift_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_9_read) begin
            r_base      <= base_addr;
            r_row       <= 2'd0;
            r_col       <= 2'd0;
            r_read_en   <= 1'b1;
            r_read_addr <= base_addr;
            r_busy      <= 1'b1;
            r_state     <= S_FULL;
          end else if (start_shift) begin
            for (int r = 0; r < 3; r++) begin
              r_pix[3*r]   <= r_pix[3*r+1];
              r_pix[3*r+1] <= r_pix[3*r+2];
            end
            r_base      <= base_addr;
            r_row       <= 2'd0;
            r_col       <= 2'd2;
            r_read_en   <= 1'b1;
            r_read_addr <= base_addr + ADDR_W'(2);
            r_busy      <= 1'b1;
            r_state     <= S_SHIFT;
          end
        end
        S_FULL, S_SHIFT: begin
          if (mem.read_valid) begin
            r_pix[w_cap_idx] <= mem.read_data;
            if (w_last) begin
              r_read_en        <= 1'b0;
              r_read_data_done <= (r_state == S_FULL);
              r_shift_done     <= (r_state == S_SHIFT);
              r_state          <= S_DONE;
            end else begin
              r_row       <= w_next_row;
              r_col       <= w_next_col;
              r_read_addr <= f_addr(r_base, w_next_row, w_next_col);
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem.read_en     = r_read_en;
  assign mem.read_addr   = r_read_addr;
  assign read_data_done  = r_read_data_done;
  assign shift_done      = r_shift_done;
  assign busy            = r_busy;

  for (genvar g = 0; g < 9; g++) begin : g_window
    assign window[g*PIX_W +: PIX_W] = r_pix[g];
  end

endmodule
